vector_seq: RTL

- Upstream control stage for the program counter.
- On power-up reset, a soft-reset request, NMI or unmasked IRQ, it fetches the 16-bit vector over the system bus and writes it into the PC, low byte first, through the PC's byte write strobes.
- While sequencing it owns the address bus, and the instruction sequencer holds off.

---
 rtl/vector_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vector_seq.sv
// rtl/vector_seq.sv - reset/NMI/IRQ vector fetch sequencer feeding the PC byte strobes
module vector_seq #(
  parameter int ADDR_N = 16,
  parameter int DATA_N = 8,
  parameter logic [ADDR_N-1:0] NMI_VEC = 16'hfffa,
  parameter logic [ADDR_N-1:0] RST_VEC = 16'hfffc,
  parameter logic [ADDR_N-1:0] IRQ_VEC = 16'hfffe
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst,
  input  logic              nmi,
  input  logic              irq,
  input  logic              irq_mask,
  input  logic              boundary,
  input  logic              rdy,
  input  logic [DATA_N-1:0] data_in,
  output logic [ADDR_N-1:0] addr,
  output logic              addr_oe,
  output logic              pc_wel,
  output logic              pc_weh,
  output logic [DATA_N-1:0] pc_data,
  output logic              busy,
  output logic              done,
  output logic              set_i,
  output logic [1:0]        src
);

  typedef enum logic [2:0] {BOOT, IDLE, FETCH_L, FETCH_H, DONE} state_e;

  localparam logic [1:0] SRC_RST = 2'd0;
  localparam logic [1:0] SRC_NMI = 2'd1;
  localparam logic [1:0] SRC_IRQ = 2'd2;

  state_e            state_q, state_d;
  logic [1:0]        src_q, src_d;
  logic [ADDR_N-1:0] vec_q, vec_d;
  logic              nmi_q;
  logic              nmi_pend_q, nmi_pend_d;
  logic              start_nmi;

  assign pc_data = data_in;
  assign src     = src_q;

  // A fresh edge in the same cycle an NMI sequence starts must survive the clear.
  assign nmi_pend_d = (nmi & ~nmi_q) | (nmi_pend_q & ~start_nmi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      src_q      <= SRC_RST;
      vec_q      <= RST_VEC;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      vec_q      <= vec_d;
      nmi_q      <= nmi;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    vec_d     = vec_q;
    start_nmi = 1'b0;
    addr      = vec_q;
    addr_oe   = 1'b0;
    pc_wel    = 1'b0;
    pc_weh    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    set_i     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH_L;
        src_d   = SRC_RST;
        vec_d   = RST_VEC;
      end
      IDLE: begin
        busy = 1'b0;
        if (boundary) begin
          if (soft_rst) begin
            state_d = FETCH_L;
            src_d   = SRC_RST;
            vec_d   = RST_VEC;
          end else if (nmi_pend_q) begin
            state_d   = FETCH_L;
            src_d     = SRC_NMI;
            vec_d     = NMI_VEC;
            start_nmi = 1'b1;
          end else if (irq && !irq_mask) begin
            state_d = FETCH_L;
            src_d   = SRC_IRQ;
            vec_d   = IRQ_VEC;
          end
        end
      end
      FETCH_L: begin
        addr_oe = 1'b1;
        pc_wel  = rdy;
        if (rdy) state_d = FETCH_H;
      end
      FETCH_H: begin
        addr    = vec_q + ADDR_N'(1);
        addr_oe = 1'b1;
        pc_weh  = rdy;
        if (rdy) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        set_i   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = BOOT;
    endcase
  end

endmodule
